// File: rtl/reg_readback_unit_pkg.sv
// reg_readback_unit_pkg: shared sizes and FSM state encoding for the register readback engine.
package reg_readback_unit_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int NUM_REGS_DEF   = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        SEND    = 3'd3,
        FINISH  = 3'd4
    } state_t;
endpackage

// File: rtl/readback_out_reg.sv
// readback_out_reg: load-enabled holding register for the outgoing word and its address.
module readback_out_reg #(
    parameter int W = 37
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)     data_q <= '0;
        else if (en_i) data_q <= d_i;
    end

    assign q_o = data_q;
endmodule

// File: rtl/reg_readback_unit.sv
// reg_readback_unit: walks a wrap-around register range through a 1-cycle read port
// and streams each word with its address over a valid/ready channel.
module reg_readback_unit
    import reg_readback_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] first_addr_i,
    input  logic [ADDR_WIDTH:0]   count_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o
);
    localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [ADDR_WIDTH:0]   n;
    logic                  hs;

    assign n  = count_i > MAX_CNT ? MAX_CNT : count_i;
    assign hs = state_q == SEND && out_ready_i;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = n == '0 ? FINISH : ISSUE;
                cur_d   = first_addr_i;
                rem_d   = n;
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = SEND;
            SEND: if (hs) begin
                state_d = rem_q == ONE ? FINISH : ISSUE;
                cur_d   = cur_q + 1'b1;
                rem_d   = rem_q - ONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
        end
    end

    // The word register loads on the CAPTURE edge, when the bank data from ISSUE is on rd_data_i.
    readback_out_reg #(.W(DATA_WIDTH + ADDR_WIDTH)) u_out_reg (
        .clk_i (clk_i),
        .rst_i (reset_i),
        .en_i  (state_q == CAPTURE),
        .d_i   ({rd_data_i, cur_q}),
        .q_o   ({out_data_o, out_addr_o})
    );

    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == FINISH;
    assign rd_en_o     = state_q == ISSUE;
    assign rd_addr_o   = cur_q;
    assign out_valid_o = state_q == SEND;
endmodule

// File: tb/tb_reg_readback_unit.sv
// tb_reg_readback_unit: randomized and directed checks of the readback engine against a word-queue model.
module tb_reg_readback_unit;
    logic        clk, reset, start, busy, done, rd_en, out_valid, out_ready;
    logic [4:0]  first_addr, rd_addr, out_addr;
    logic [5:0]  count;
    logic [31:0] rd_data, out_data;

    int n_chk = 0, n_fail = 0, cyc = 0, done_cnt = 0, rd_cnt = 0, ready_mode = 0;
    logic [36:0] exp_q[$];
    logic        prev_valid = 0, prev_hs = 0, prev_rd = 0;
    logic [36:0] prev_word = '0;

    reg_readback_unit dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .first_addr_i(first_addr), .count_i(count),
        .busy_o(busy), .done_o(done), .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_addr_o(out_addr)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    function automatic logic [31:0] bank(input logic [4:0] a);
        return 32'h007fb190 + {27'd0, a};
    endfunction

    always @(posedge clk) rd_data <= rd_en ? bank(rd_addr) : 32'hdeadbeef;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Consumer: 0 always ready, 1 random, 2 stall 5 cycles per word, 3 never ready.
    initial begin
        int stall;
        stall = 0;
        out_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (!out_valid) stall = 0;
                    if (out_valid && stall < 5) begin out_ready = 0; stall++; end
                    else out_ready = 1;
                end
                default: out_ready = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [36:0] w;
        if (!reset) begin
            if (done) done_cnt++;
            if (rd_en) begin
                rd_cnt++;
                check("one_outstanding", 64'(out_valid | prev_rd), 0);
            end
            if (prev_valid && !prev_hs && out_valid)
                check("stable_during_stall", 64'({out_data, out_addr}), 64'(prev_word));
            if (out_valid && out_ready) begin
                check("word_pending", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check("word", 64'({out_data, out_addr}), 64'(w));
                end
            end
        end
        prev_valid = out_valid;
        prev_hs    = out_valid && out_ready;
        prev_rd    = rd_en;
        prev_word  = {out_data, out_addr};
    end

    task automatic push_words(input int fa, input int cnt);
        int n;
        n = cnt > 32 ? 32 : cnt;
        for (int i = 0; i < n; i++) exp_q.push_back({bank(5'((fa + i) % 32)), 5'((fa + i) % 32)});
    endtask

    task automatic dump(input int fa, input int cnt, input int mode);
        int n, t0, lat, d0, r0, bound;
        logic found;
        n = cnt > 32 ? 32 : cnt;
        push_words(fa, cnt);
        d0 = done_cnt;
        r0 = rd_cnt;
        @(posedge clk); #1;
        ready_mode = mode;
        first_addr = 5'(fa);
        count = 6'(cnt);
        start = 1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 0;
        found = 0;
        lat = -1;
        bound = mode == 0 ? 3 * n + 4 : 3 * n + 8 * n * 8 + 50;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (done) begin found = 1; lat = cyc - t0; end
        end
        check("done_timeout", 64'(found), 1);
        if (mode == 0) check("done_latency", 64'(lat), 64'(3 * n + 1));
        @(negedge clk);
        check("done_once", 64'(done_cnt - d0), 1);
        check("read_count", 64'(rd_cnt - r0), 64'(n));
        check("queue_drained", 64'(exp_q.size()), 0);
        check("idle_after", 64'(busy), 0);
    endtask

    initial begin
        int d0, r0, t0;
        logic found;
        reset = 1; start = 0; first_addr = 0; count = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("reset_outputs", 64'({busy, done, rd_en, rd_addr, out_valid, out_data, out_addr}), 0);

        // Single read with exact cycle timing
        exp_q.push_back({32'h007fb193, 5'd3});
        @(posedge clk); #1;
        ready_mode = 0; first_addr = 3; count = 1; start = 1;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        check("s1_rd_en", 64'(rd_en), 1);
        check("s1_rd_addr", 64'(rd_addr), 3);
        check("s1_busy", 64'(busy), 1);
        @(negedge clk);
        check("s1_valid_early", 64'(out_valid), 0);
        @(negedge clk);
        check("s1_valid", 64'(out_valid), 1);
        check("s1_data", 64'(out_data), 64'h007fb193);
        check("s1_addr", 64'(out_addr), 3);
        @(negedge clk);
        check("s1_done", 64'(done), 1);
        check("s1_busy_finish", 64'(busy), 1);
        @(negedge clk);
        check("s1_done_low", 64'(done), 0);
        check("s1_busy_low", 64'(busy), 0);

        // Wrapping range with backpressure, zero count, clamped count
        dump(30, 4, 2);
        dump(0, 0, 0);
        dump(0, 40, 0);

        // START pulses during a dump and during FINISH are ignored
        push_words(5, 3);
        d0 = done_cnt;
        r0 = rd_cnt;
        @(posedge clk); #1;
        ready_mode = 0; first_addr = 5; count = 3; start = 1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            start = (k == 4 || k == 10);
            first_addr = 20;
            count = 2;
            @(negedge clk);
            if (k == 10) check("s4_done_at_finish", 64'(done), 1);
        end
        @(posedge clk); #1 start = 0;
        repeat (15) @(negedge clk);
        check("s4_done_once", 64'(done_cnt - d0), 1);
        check("s4_reads", 64'(rd_cnt - r0), 3);
        check("s4_drained", 64'(exp_q.size()), 0);
        check("s4_idle", 64'(busy), 0);

        // Reset while a word waits in SEND
        push_words(10, 3);
        d0 = done_cnt;
        @(posedge clk); #1;
        ready_mode = 3; first_addr = 10; count = 3; start = 1;
        @(posedge clk); #1 start = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = out_valid;
        end
        check("s5_reach_send", 64'(found), 1);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        check("s5_reset_outputs", 64'({busy, done, rd_en, rd_addr, out_valid, out_data, out_addr}), 0);
        exp_q.delete();
        repeat (5) @(negedge clk);
        check("s5_no_done", 64'(done_cnt - d0), 0);
        check("s5_idle", 64'(busy), 0);
        dump(3, 1, 0);

        // Random dumps with random consumer behaviour
        for (int i = 0; i < 25; i++) begin
            t0 = $urandom_range(0, 3);
            dump(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), t0 == 0 ? 0 : (t0 == 1 ? 2 : 1));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
